// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave endpoint.
package spi_pkg;

  localparam int unsigned SPI_FRAME_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } spi_slv_state_t;

endpackage

// File: rtl/spi_slave_txrx_if.sv
// SPI bus pins plus the tx/rx word handshake of the slave endpoint.
interface spi_slave_txrx_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = SPI_FRAME_W
) ();

  logic              sclk;
  logic              cs;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              tx_underrun;
  logic              frame_abort;

  modport slave (
    input  sclk, cs, mosi, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_abort
  );

  modport master (
    output sclk, cs, mosi, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_abort
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop input synchroniser with rise/fall pulses from one extra delayed copy.
// SYNC_STAGES must be at least 2.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync   = r_sync[SYNC_STAGES-1];
  assign o_rise_c = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall_c = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_txrx.sv
// Oversampled full-duplex SPI mode-0 slave, LSB first, with a one-word tx holding register.
module spi_slave_txrx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_FRAME_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_slave_txrx_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic w_sclk_sync_unused;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_sync;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_mosi_sync;
  logic w_mosi_rise_unused;
  logic w_mosi_fall_unused;

  spi_slv_state_t r_state;
  spi_slv_state_t w_state_nxt;

  logic [CNT_W-1:0]       r_cnt,         w_cnt_nxt;
  logic [DATA_W-1:0]      r_rx_shift,    w_rx_shift_nxt;
  logic [DATA_W-1:0]      r_tx_shift,    w_tx_shift_nxt;
  logic [DATA_W-1:0]      r_hold,        w_hold_nxt;
  logic                   r_tx_ready,    w_tx_ready_nxt;
  logic                   r_miso,        w_miso_nxt;
  logic [DATA_W-1:0]      r_rx_data,     w_rx_data_nxt;
  logic                   r_rx_valid,    w_rx_valid_nxt;
  logic                   r_tx_underrun, w_tx_underrun_nxt;
  logic                   r_frame_abort, w_frame_abort_nxt;
  logic                   r_busy;
  logic [SYNC_STAGES-1:0] r_settle;
  logic                   r_cs_armed;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_d      (bus.sclk),
    .o_sync   (w_sclk_sync_unused),
    .o_rise_c (w_sclk_rise),
    .o_fall_c (w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_d      (bus.cs),
    .o_sync   (w_cs_sync),
    .o_rise_c (w_cs_rise),
    .o_fall_c (w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_d      (bus.mosi),
    .o_sync   (w_mosi_sync),
    .o_rise_c (w_mosi_rise_unused),
    .o_fall_c (w_mosi_fall_unused)
  );

  // Arm frame start only after cs has been seen high with a flushed synchroniser,
  // so a cs held low across reset release cannot start a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle   <= '0;
      r_cs_armed <= 1'b0;
    end else begin
      r_settle   <= {r_settle[SYNC_STAGES-2:0], 1'b1};
      r_cs_armed <= r_cs_armed | (&r_settle & w_cs_sync);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, datapath and output decode.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_rx_shift_nxt    = r_rx_shift;
    w_tx_shift_nxt    = r_tx_shift;
    w_hold_nxt        = r_hold;
    w_tx_ready_nxt    = r_tx_ready;
    w_miso_nxt        = r_miso;
    w_rx_data_nxt     = r_rx_data;
    w_rx_valid_nxt    = 1'b0;
    w_tx_underrun_nxt = 1'b0;
    w_frame_abort_nxt = 1'b0;

    // A handshake on the cs_fall clk lands in the holding register for the next frame.
    if (bus.tx_valid && r_tx_ready) begin
      w_hold_nxt     = bus.tx_data;
      w_tx_ready_nxt = 1'b0;
    end

    case (r_state)
      IDLE: begin
        w_miso_nxt = 1'b0;
        if (w_cs_fall && r_cs_armed) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = '0;
          if (!r_tx_ready) begin
            w_tx_shift_nxt = r_hold;
            w_miso_nxt     = r_hold[0];
            w_tx_ready_nxt = 1'b1;
          end else begin
            w_tx_shift_nxt    = '0;
            w_tx_underrun_nxt = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (w_cs_rise && (r_cnt < CNT_FULL)) begin
          w_frame_abort_nxt = 1'b1;
          w_state_nxt       = IDLE;
          w_miso_nxt        = 1'b0;
          w_tx_shift_nxt    = '0;
        end else if (r_cnt == CNT_FULL) begin
          w_rx_data_nxt  = r_rx_shift;
          w_rx_valid_nxt = 1'b1;
          w_miso_nxt     = 1'b0;
          w_state_nxt    = w_cs_rise ? IDLE : WAIT_CS;
        end else begin
          if (w_sclk_rise) begin
            w_rx_shift_nxt = {w_mosi_sync, r_rx_shift[DATA_W-1:1]};
            w_cnt_nxt      = r_cnt + CNT_W'(1);
          end
          if (w_sclk_fall) begin
            w_tx_shift_nxt = r_tx_shift >> 1;
            w_miso_nxt     = r_tx_shift[1];
          end
        end
      end

      WAIT_CS: begin
        w_miso_nxt = 1'b0;
        if (w_cs_rise) w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
        w_miso_nxt  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_rx_shift    <= '0;
      r_tx_shift    <= '0;
      r_hold        <= '0;
      r_tx_ready    <= 1'b1;
      r_miso        <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_abort <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_rx_shift    <= w_rx_shift_nxt;
      r_tx_shift    <= w_tx_shift_nxt;
      r_hold        <= w_hold_nxt;
      r_tx_ready    <= w_tx_ready_nxt;
      r_miso        <= w_miso_nxt;
      r_rx_data     <= w_rx_data_nxt;
      r_rx_valid    <= w_rx_valid_nxt;
      r_tx_underrun <= w_tx_underrun_nxt;
      r_frame_abort <= w_frame_abort_nxt;
      r_busy        <= (w_state_nxt != IDLE);
    end
  end

  assign bus.miso        = r_miso;
  assign bus.tx_ready    = r_tx_ready;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.busy        = r_busy;
  assign bus.tx_underrun = r_tx_underrun;
  assign bus.frame_abort = r_frame_abort;

endmodule

// File: tb/tb_spi_slave_txrx.sv
// Directed bench for spi_slave_txrx: a behavioural mode-0 master drives the bus.
module tb_spi_slave_txrx;

  localparam int HALF = 8;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  int n_rxv    = 0;
  int n_und    = 0;
  int n_abt    = 0;
  int n_miso   = 0;
  int n_busy   = 0;
  int n_ready  = 0;

  spi_slave_txrx_if bus ();

  spi_slave_txrx u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 100 MHz system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Event counters sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_valid)          n_rxv   <= n_rxv + 1;
    if (bus.tx_underrun)       n_und   <= n_und + 1;
    if (bus.frame_abort)       n_abt   <= n_abt + 1;
    if (!bus.cs && bus.miso)   n_miso  <= n_miso + 1;
    if (bus.busy)              n_busy  <= n_busy + 1;
    if (bus.tx_ready)          n_ready <= n_ready + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Handshake one word into the holding register, bounded wait on tx_ready.
  task automatic push(input logic [11:0] w);
    int t;
    t = 0;
    while (!bus.tx_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!bus.tx_ready) check("push_ready_timeout", 32'(bus.tx_ready), 32'd1);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // n sclk pulses; master samples miso just before each rising edge.
  task automatic pulses(input logic [11:0] din, input int n, input bit cs_last,
                        output logic [15:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      bus.mosi = (i < 12) ? din[i] : 1'b0;
      wait_clks(HALF);
      if (i < 16) bits[i] = bus.miso;
      bus.sclk = 1'b1;
      if (cs_last && (i == n - 1)) bus.cs = 1'b1;
      wait_clks(HALF);
      bus.sclk = 1'b0;
    end
    bus.mosi = 1'b0;
  endtask

  task automatic xfer(input logic [11:0] din, input int n, input bit cs_last,
                      output logic [15:0] bits);
    bus.cs = 1'b0;
    wait_clks(HALF);
    pulses(din, n, cs_last, bits);
    wait_clks(HALF);
    bus.cs = 1'b1;
    wait_clks(2 * HALF);
  endtask

  initial begin
    logic [15:0] bits;
    logic [15:0] bits2;
    int rxv0, und0, abt0, miso0, busy0, ready0;

    rst_n        = 1'b0;
    bus.sclk     = 1'b0;
    bus.cs       = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    wait_clks(4);

    check("rst_flags", 32'({bus.miso, bus.tx_ready, bus.rx_valid, bus.busy,
                            bus.tx_underrun, bus.frame_abort}), 32'b010000);
    check("rst_rx_data", 32'(bus.rx_data), 32'h000);
    rst_n = 1'b1;
    wait_clks(6);

    // Loopback: rx A5C, tx 3E1.
    push(12'h3E1);
    check("lb_push_ready_low", 32'(bus.tx_ready), 32'd0);
    rxv0 = n_rxv; und0 = n_und; abt0 = n_abt; busy0 = n_busy;
    xfer(12'hA5C, 12, 1'b0, bits);
    check("lb_rx_data", 32'(bus.rx_data), 32'hA5C);
    check("lb_rx_valid_cnt", 32'(n_rxv - rxv0), 32'd1);
    check("lb_miso_bits", 32'(bits[11:0]), 32'h3E1);
    check("lb_underrun_cnt", 32'(n_und - und0), 32'd0);
    check("lb_abort_cnt", 32'(n_abt - abt0), 32'd0);
    check("lb_busy_seen", 32'((n_busy - busy0) > 0), 32'd1);
    check("lb_idle_flags", 32'({bus.busy, bus.tx_ready}), 32'b01);

    // Abort after 5 bits of FFF.
    rxv0 = n_rxv; abt0 = n_abt; und0 = n_und;
    xfer(12'hFFF, 5, 1'b0, bits);
    check("ab_abort_cnt", 32'(n_abt - abt0), 32'd1);
    check("ab_rx_valid_cnt", 32'(n_rxv - rxv0), 32'd0);
    check("ab_rx_data_kept", 32'(bus.rx_data), 32'hA5C);
    check("ab_underrun_cnt", 32'(n_und - und0), 32'd1);
    check("ab_busy", 32'(bus.busy), 32'd0);

    // cs rises together with the 12th sclk rise: cs wins, frame aborts.
    rxv0 = n_rxv; abt0 = n_abt;
    xfer(12'h0F0, 12, 1'b1, bits);
    check("sim_abort_cnt", 32'(n_abt - abt0), 32'd1);
    check("sim_rx_valid_cnt", 32'(n_rxv - rxv0), 32'd0);
    check("sim_rx_data_kept", 32'(bus.rx_data), 32'hA5C);

    // Underrun: nothing preloaded.
    rxv0 = n_rxv; und0 = n_und; miso0 = n_miso;
    xfer(12'h6B2, 12, 1'b0, bits);
    check("ur_underrun_cnt", 32'(n_und - und0), 32'd1);
    check("ur_miso_high_cycles", 32'(n_miso - miso0), 32'd0);
    check("ur_rx_data", 32'(bus.rx_data), 32'h6B2);
    check("ur_rx_valid_cnt", 32'(n_rxv - rxv0), 32'd1);

    // Back-to-back: 001 preloaded, 800 handshaken during frame 1.
    push(12'h001);
    ready0 = 0;
    fork
      xfer(12'h0F0, 12, 1'b0, bits);
      begin
        wait_clks(40);
        push(12'h800);
        ready0 = n_ready;
      end
    join
    check("bb_f1_miso", 32'(bits[11:0]), 32'h001);
    check("bb_f1_rx", 32'(bus.rx_data), 32'h0F0);
    wait_clks(10);
    check("bb_ready_low_gap", 32'(n_ready - ready0), 32'd0);
    check("bb_ready_low", 32'(bus.tx_ready), 32'd0);
    und0 = n_und;
    xfer(12'h70E, 12, 1'b0, bits2);
    check("bb_f2_miso", 32'(bits2[11:0]), 32'h800);
    check("bb_f2_rx", 32'(bus.rx_data), 32'h70E);
    check("bb_f2_underrun", 32'(n_und - und0), 32'd0);

    // 14 sclk pulses in one frame.
    push(12'hFFF);
    rxv0 = n_rxv;
    xfer(12'h5A5, 14, 1'b0, bits);
    check("ex_rx_data", 32'(bus.rx_data), 32'h5A5);
    check("ex_rx_valid_cnt", 32'(n_rxv - rxv0), 32'd1);
    check("ex_miso_bits", 32'(bits[11:0]), 32'hFFF);
    check("ex_miso_extra", 32'(bits[13:12]), 32'd0);

    // Reset mid-frame after bit 6.
    push(12'hFFF);
    bus.cs = 1'b0;
    wait_clks(HALF);
    push(12'h0F0);
    pulses(12'h3FF, 6, 1'b0, bits);
    wait_clks(5);
    check("mr_pre_flags", 32'({bus.miso, bus.busy, bus.tx_ready}), 32'b110);
    rst_n = 1'b0;
    #1;
    check("mr_rst_flags", 32'({bus.miso, bus.tx_ready, bus.rx_valid, bus.busy,
                               bus.tx_underrun, bus.frame_abort}), 32'b010000);
    check("mr_rst_rx_data", 32'(bus.rx_data), 32'h000);
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(5);
    rxv0 = n_rxv; busy0 = n_busy;
    pulses(12'h123, 12, 1'b0, bits);
    wait_clks(10);
    check("mr_no_frame_rxv", 32'(n_rxv - rxv0), 32'd0);
    check("mr_no_frame_busy", 32'(n_busy - busy0), 32'd0);
    bus.cs = 1'b1;
    wait_clks(2 * HALF);
    rxv0 = n_rxv; und0 = n_und; miso0 = n_miso;
    xfer(12'h123, 12, 1'b0, bits);
    check("mr_rx_data", 32'(bus.rx_data), 32'h123);
    check("mr_rx_valid_cnt", 32'(n_rxv - rxv0), 32'd1);
    check("mr_underrun_cnt", 32'(n_und - und0), 32'd1);
    check("mr_miso_high_cycles", 32'(n_miso - miso0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_txrx.md
Name: spi_slave_txrx

Overview:
Full-duplex SPI peripheral endpoint that runs on the system clock and sits opposite the team's SPI master on the sclk/cs/mosi/miso bus. It receives 12-bit LSB-first frames on mosi and transmits a preloaded 12-bit word LSB-first on miso, the direction the current bus leaves unused. sclk, cs and mosi are oversampled and synchronised, so the block has no sclk clock domain.

Parameters:
DATA_W, 12, frame length in bits; also the width of tx_data and rx_data.
SYNC_STAGES, 2, flip-flop depth of the input synchronisers on sclk, cs and mosi (minimum 2).

Ports:
clk  input  1  system clock; must be at least 4x the sclk frequency.
rst_n  input  1  reset; asynchronous assert, active-low.
sclk  input  1  SPI serial clock from the master; idle low.
cs  input  1  chip select from the master; active-low.
mosi  input  1  serial data from the master.
miso  output  1  serial data to the master.
tx_data  input  DATA_W  word to transmit in the next frame.
tx_valid  input  1  tx_data is valid; transfer occurs when tx_valid and tx_ready are both high on a clk edge.
tx_ready  output  1  holding register is empty.
rx_data  output  DATA_W  last complete received word.
rx_valid  output  1  one-clk pulse when rx_data is updated.
busy  output  1  a frame is in progress (state is not IDLE).
tx_underrun  output  1  one-clk pulse when a frame starts with the holding register empty.
frame_abort  output  1  one-clk pulse when cs deasserts before DATA_W bits have been received.

Behaviour:
- Reset values: miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, tx_underrun=0, frame_abort=0, state=IDLE, bit counter=0, holding register empty.
- Synchronisers: sclk, cs and mosi each pass through SYNC_STAGES flops. The synchronisers reset high for cs and low for sclk and mosi.
- Edge detection: one extra registered copy of synced sclk and synced cs produces single-cycle pulses sclk_rise, sclk_fall, cs_fall and cs_rise.
- Protocol: SPI mode 0, LSB first.
  - Slave samples mosi on sclk_rise.
  - Slave updates miso on sclk_fall.
  - Bit 0 is driven on miso on the clk after cs_fall.
- Holding register:
  - Loaded on a tx_valid and tx_ready handshake; tx_ready drops on the next clk.
  - Emptied, and tx_ready raised, when the register is copied into the tx shift register at cs_fall.
  - A handshake on the same clk as cs_fall is not used for that frame; the word is kept for the next frame.
- State IDLE: miso=0. On cs_fall go to SHIFT and clear the bit counter.
  - Holding register full: load it into the tx shift register.
  - Holding register empty: load 0 and pulse tx_underrun.
- State SHIFT:
  - On each sclk_rise: rx shift register <= {mosi_sync, rx_shift[DATA_W-1:1]}; counter += 1.
  - On each sclk_fall with counter < DATA_W: shift tx right; miso = new bit 0.
  - When counter reaches DATA_W: on the next clk, rx_data <= rx_shift, rx_valid pulses for 1 clk, and state moves to WAIT_CS.
- State WAIT_CS: miso=0; any further sclk edges are ignored. On cs_rise go to IDLE.
- cs_rise in SHIFT before DATA_W bits:
  - Pulse frame_abort; go to IDLE.
  - rx_data and rx_valid are left unchanged; the partial tx word is discarded.
- sclk_rise and cs_rise on the same clk: cs_rise wins; the bit is not sampled.
- Counter width: $clog2(DATA_W+1) bits; it never wraps within a frame.
- rx latency: rx_valid asserts SYNC_STAGES+2 clks after the final physical sclk rising edge.
- rst_n low mid-frame: all outputs return to reset values immediately. After release the block waits in IDLE for a fresh cs_fall; a cs already low at release does not start a frame.
- miso is driven continuously (no tristate); external bus muxing is outside this block.

Decomposition:
- Shared package spi_pkg:
  - typedef enum logic [1:0] spi_slv_state_t {IDLE, SHIFT, WAIT_CS}.
  - localparam SPI_FRAME_W = 12, used as the default for DATA_W.
- One sub-module: spi_sync_edge, a parameterised SYNC_STAGES synchroniser with registered rise/fall pulse outputs and a reset-value parameter. It is instantiated for sclk and cs; mosi uses the synchroniser only.

Test Plan:
- Loopback with the existing master: master din=12'hA5C, tx_data=12'h3E1 preloaded -> rx_data=12'hA5C and rx_valid pulses once; miso bits observed on master posedges = 1,0,0,0,0,1,1,1,1,1,0,0 (12'h3E1 LSB first).
- Underrun: no tx_valid before cs falls -> tx_underrun pulses 1 clk after cs_fall detection; miso=0 for the whole frame; the rx word is still captured correctly.
- Abort: cs raised after 5 sclk rising edges with mosi pattern 12'hFFF -> frame_abort pulses, no rx_valid, rx_data keeps its previous value 12'hA5C, state returns to IDLE.
- Back-to-back: tx_data=12'h001 then 12'h800 handshaken during frame 1 -> frame 2 transmits 12'h800; tx_ready is low between the handshake and frame 2's cs_fall.
- Extra clocks: 14 sclk pulses in one cs-low window with mosi data 12'h5A5 -> rx_data=12'h5A5, exactly one rx_valid, miso=0 during pulses 13-14.
- Reset mid-frame: rst_n low after bit 6 -> all outputs immediately at reset values. A subsequent full frame with data 12'h123 is received correctly, and no frame starts until cs is raised and lowered again.
